// File: rtl/regfile.sv
// 32 x 32-bit general-purpose register file: one write port from write-back and
// two combinational read ports for decode, with same-cycle write-to-read bypass.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en_s;
    logic              byp1_s;
    logic              byp2_s;

    // x0 is hard-wired, so a write aimed at it is never committed or bypassed.
    assign wr_en_s = we && (waddr != {ADDR_W{1'b0}});
    assign byp1_s  = wr_en_s && re1 && (raddr1 == waddr);
    assign byp2_s  = wr_en_s && re2 && (raddr2 == waddr);

    // Next-state of the storage array: only the addressed register changes.
    always_comb begin
        regs_d[0] = {DATA_W{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en_s && (waddr == ADDR_W'(i))) begin
                regs_d[i] = wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage flops; reset clears everything without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1 priority chain: reset, x0, bypass, stored value, disabled.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        if (rst) begin
            rdata1 = {DATA_W{1'b0}};
        end else if (raddr1 == {ADDR_W{1'b0}}) begin
            rdata1 = {DATA_W{1'b0}};
        end else if (byp1_s) begin
            rdata1 = wdata;
        end else if (re1) begin
            rdata1 = regs_q[raddr1];
        end else begin
            rdata1 = {DATA_W{1'b0}};
        end
    end

    // Read port 2 priority chain, independent of port 1.
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        if (rst) begin
            rdata2 = {DATA_W{1'b0}};
        end else if (raddr2 == {ADDR_W{1'b0}}) begin
            rdata2 = {DATA_W{1'b0}};
        end else if (byp2_s) begin
            rdata2 = wdata;
        end else if (re2) begin
            rdata2 = regs_q[raddr2];
        end else begin
            rdata2 = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: hand-computed vectors, immediate assertions.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int vectors;
    int miscompares;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        // populate, then reset mid-cycle with no clock edge
        write_reg(5'd1, 32'h1234_5678);
        write_reg(5'd31, 32'hCAFE_F00D);
        raddr1 = 5'd1; raddr2 = 5'd31;
        #1;
        check("pre_reset_x1", rdata1, 32'h1234_5678);
        check("pre_reset_x31", rdata2, 32'hCAFE_F00D);
        rst = 1'b1;
        #1;
        check("rst_imm_rd1", rdata1, 32'h0);
        check("rst_imm_rd2", rdata2, 32'h0);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(i);
            #0.1;
            check("reset_clear_p1", rdata1, 32'h0);
            check("reset_clear_p2", rdata2, 32'h0);
        end

        // async release: first write lands at the next edge
        tick();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        write_reg(5'd10, 32'h0000_0010);
        raddr1 = 5'd10;
        #1;
        check("post_release_write", rdata1, 32'h0000_0010);

        // write then read
        write_reg(5'd5, 32'hDEAD_BEEF);
        raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        check("wr_rd_p1", rdata1, 32'hDEAD_BEEF);
        check("wr_rd_p2", rdata2, 32'hDEAD_BEEF);
        re1 = 1'b0;
        #1;
        check("re_off_stored", rdata1, 32'h0);
        re1 = 1'b1;

        // bypass on port 1 only
        write_reg(5'd7, 32'h1111_1111);
        we = 1'b1; waddr = 5'd7; wdata = 32'h2222_2222;
        raddr1 = 5'd7; re1 = 1'b1; raddr2 = 5'd7; re2 = 1'b0;
        #1;
        check("bypass_p1", rdata1, 32'h2222_2222);
        check("bypass_p2_disabled", rdata2, 32'h0);
        tick();
        we = 1'b0; re2 = 1'b1;
        #1;
        check("bypass_next_p1", rdata1, 32'h2222_2222);
        check("bypass_next_p2", rdata2, 32'h2222_2222);

        // both ports bypass in the same cycle
        we = 1'b1; waddr = 5'd7; wdata = 32'h3333_4444;
        #1;
        check("dual_bypass_p1", rdata1, 32'h3333_4444);
        check("dual_bypass_p2", rdata2, 32'h3333_4444);
        tick();
        we = 1'b0;

        // x0 protection
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("x0_same_p1", rdata1, 32'h0);
        check("x0_same_p2", rdata2, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("x0_next_p1", rdata1, 32'h0);
        check("x0_next_p2", rdata2, 32'h0);

        // reset during write
        write_reg(5'd3, 32'hA5A5_A5A5);
        raddr1 = 5'd3;
        #1;
        check("x3_before", rdata1, 32'hA5A5_A5A5);
        we = 1'b1; waddr = 5'd3; wdata = 32'h5A5A_5A5A; rst = 1'b1;
        #1;
        check("rst_overrides_bypass", rdata1, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("rst_during_write", rdata1, 32'h0);

        // independent ports while writing another register
        write_reg(5'd1, 32'h0000_0001);
        write_reg(5'd31, 32'h8000_0000);
        we = 1'b1; waddr = 5'd2; wdata = 32'h0000_0002;
        raddr1 = 5'd31; raddr2 = 5'd1;
        #1;
        check("indep_p1", rdata1, 32'h8000_0000);
        check("indep_p2", rdata2, 32'h0000_0001);
        tick();
        we = 1'b0; raddr1 = 5'd2;
        #1;
        check("indep_x2", rdata1, 32'h0000_0002);

        // back-to-back writes: each bypass shows its own data, last wins
        we = 1'b1; waddr = 5'd9; wdata = 32'hAAAA_0001; raddr1 = 5'd9;
        #1;
        check("b2b_bypass_1", rdata1, 32'hAAAA_0001);
        tick();
        wdata = 32'hAAAA_0002;
        #1;
        check("b2b_bypass_2", rdata1, 32'hAAAA_0002);
        tick();
        we = 1'b0;
        #1;
        check("b2b_last_wins", rdata1, 32'hAAAA_0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
